// File: rtl/fu_issue_scheduler_pkg.sv
// Shared types and constants for the FU issue scheduler.
// Optional perf counters are enabled by defining ISSUE_PERF_CNT_EN.
package fu_issue_scheduler_pkg;

    localparam int SUPERSCALAR_WAYS = 3;

    localparam int N_REQ     = 8;
    localparam int N_WAYS    = SUPERSCALAR_WAYS;
    localparam int N_ALU     = 3;
    localparam int N_MULT    = 2;
    localparam int MULT_BUSY = 4;
    localparam int ROB_W     = 5;

    localparam int IDX_W     = $clog2(N_REQ);
    localparam int ALU_CNT_W = $clog2(N_ALU + 1);
    localparam int MCNT_W    = (MULT_BUSY > 1) ? $clog2(MULT_BUSY) : 1;
    localparam int POP_W     = $clog2(N_WAYS + 1);

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_LSU  = 2'd2,
        FU_RSVD = 2'd3
    } fu_class_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        fu_class_t        fu_class;
        logic [1:0]       unit;
    } sched_grant_t;

    // Age relative to the ROB head; modular so wrapped indices rank correctly.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                                 input logic [ROB_W-1:0] head);
        return idx - head;
    endfunction

    function automatic logic class_has_unit(input fu_class_t             cls,
                                            input logic [ALU_CNT_W-1:0] alu_used,
                                            input logic [N_MULT-1:0]    mult_free,
                                            input logic                 lsu_free);
        logic ok;
        ok = 1'b0;
        case (cls)
            FU_ALU:  ok = (alu_used < ALU_CNT_W'(N_ALU));
            FU_MULT: ok = |mult_free;
            FU_LSU:  ok = lsu_free;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fu_issue_scheduler_if.sv
// Request/grant bundle between the reservation station and the issue scheduler.
interface fu_issue_scheduler_if;
    import fu_issue_scheduler_pkg::*;

    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][1:0]        req_class;
    logic [N_REQ-1:0][ROB_W-1:0]  req_rob_idx;
    logic [ROB_W-1:0]             rob_head;
    logic                         squash;
    logic                         lsu_done;
    logic                         issue_en;

    logic [N_WAYS-1:0]            grant_valid;
    logic [N_WAYS-1:0][IDX_W-1:0] grant_idx;
    logic [N_WAYS-1:0][1:0]       grant_class;
    logic [N_WAYS-1:0][1:0]       grant_unit;
    logic [N_MULT-1:0]            mult_busy;
    logic                         lsu_busy;

    modport master (
        output req_valid, req_class, req_rob_idx, rob_head, squash, lsu_done, issue_en,
        input  grant_valid, grant_idx, grant_class, grant_unit, mult_busy, lsu_busy
    );

    modport slave (
        input  req_valid, req_class, req_rob_idx, rob_head, squash, lsu_done, issue_en,
        output grant_valid, grant_idx, grant_class, grant_unit, mult_busy, lsu_busy
    );

endinterface

// File: rtl/fu_issue_scheduler_age_priority_select.sv
// Picks the oldest (smallest age) entry among those enabled by mask; ties go to the lower index.
module fu_issue_scheduler_age_priority_select #(
    parameter int N  = 8,
    parameter int AW = 5
) (
    input  logic [N-1:0]         mask,
    input  logic [N-1:0][AW-1:0] age,
    output logic [N-1:0]         onehot,
    output logic                 found
);

    logic [AW-1:0] best;

    always_comb begin
        onehot = '0;
        found  = 1'b0;
        best   = '0;
        // Strict less-than keeps the earlier (lower) index on equal ages.
        for (int i = 0; i < N; i++) begin
            if (mask[i] && (!found || (age[i] < best))) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                best      = age[i];
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fu_issue_scheduler.sv
// Oldest-first issue arbitration of RS candidates onto issue slots with ALU/MULT/LSU occupancy.
// Define ISSUE_PERF_CNT_EN to add the perf_issued / perf_struct_stall counters.
module fu_issue_scheduler
    import fu_issue_scheduler_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    fu_issue_scheduler_if.slave   bus
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_struct_stall
`endif
);

    logic [N_MULT-1:0][MCNT_W-1:0] mult_cnt_reg;
    logic                          lsu_busy_reg;

    logic [N_REQ-1:0][ROB_W-1:0]   age;
    logic [N_MULT-1:0]             mult_free0;
    logic                          lsu_free0;
    logic                          issue_gate;
    logic [N_MULT-1:0]             mult_load;
    logic                          lsu_take;

    // Grants are forced low while reset is asserted, independent of the clock.
    assign issue_gate = reset && bus.issue_en && !bus.squash;
    assign lsu_free0  = !lsu_busy_reg || bus.lsu_done;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_age
        assign age[gi] = rob_age(bus.req_rob_idx[gi], bus.rob_head);
    end

    for (genvar gi = 0; gi < N_MULT; gi++) begin : g_mult_free
        assign mult_free0[gi]    = (mult_cnt_reg[gi] == '0);
        assign bus.mult_busy[gi] = (mult_cnt_reg[gi] != '0);
    end

    assign bus.lsu_busy = lsu_busy_reg;

    // Each slot sees the units and entries left over by the slots before it.
    for (genvar gi = 0; gi < N_WAYS; gi++) begin : slot_g
        logic [N_REQ-1:0]     taken_in, taken_out, elig, onehot;
        logic [ALU_CNT_W-1:0] alu_in, alu_out;
        logic [N_MULT-1:0]    mult_in, mult_out, mult_pick;
        logic                 lsu_in, lsu_out;
        logic                 found, fire;
        logic [IDX_W-1:0]     sel_idx;
        fu_class_t            sel_class;
        logic [1:0]           sel_unit;
        sched_grant_t         grant;

        if (gi == 0) begin : g_first
            assign taken_in = '0;
            assign alu_in   = '0;
            assign mult_in  = mult_free0;
            assign lsu_in   = lsu_free0;
        end else begin : g_chain
            assign taken_in = slot_g[gi-1].taken_out;
            assign alu_in   = slot_g[gi-1].alu_out;
            assign mult_in  = slot_g[gi-1].mult_out;
            assign lsu_in   = slot_g[gi-1].lsu_out;
        end

        always_comb begin
            elig = '0;
            for (int i = 0; i < N_REQ; i++) begin
                elig[i] = bus.req_valid[i] && !taken_in[i] &&
                          class_has_unit(fu_class_t'(bus.req_class[i]), alu_in, mult_in, lsu_in);
            end
        end

        fu_issue_scheduler_age_priority_select #(
            .N  (N_REQ),
            .AW (ROB_W)
        ) u_select (
            .mask   (elig),
            .age    (age),
            .onehot (onehot),
            .found  (found)
        );

        assign fire      = found && issue_gate;
        assign mult_pick = mult_in & (~mult_in + N_MULT'(1));

        always_comb begin
            sel_idx   = '0;
            sel_class = FU_ALU;
            for (int i = 0; i < N_REQ; i++) begin
                if (onehot[i]) begin
                    sel_idx   = IDX_W'(i);
                    sel_class = fu_class_t'(bus.req_class[i]);
                end
            end
        end

        always_comb begin
            taken_out = taken_in;
            alu_out   = alu_in;
            mult_out  = mult_in;
            lsu_out   = lsu_in;
            sel_unit  = '0;
            if (fire) begin
                taken_out = taken_in | onehot;
                case (sel_class)
                    FU_ALU: begin
                        sel_unit = 2'(alu_in);
                        alu_out  = alu_in + ALU_CNT_W'(1);
                    end
                    FU_MULT: begin
                        for (int m = 0; m < N_MULT; m++) begin
                            if (mult_pick[m]) sel_unit = 2'(m);
                        end
                        mult_out = mult_in & ~mult_pick;
                    end
                    FU_LSU:  lsu_out = 1'b0;
                    default: ;
                endcase
            end
        end

        assign grant.valid    = fire;
        assign grant.idx      = fire ? sel_idx : '0;
        assign grant.fu_class = fire ? sel_class : FU_ALU;
        assign grant.unit     = fire ? sel_unit : '0;

        assign bus.grant_valid[gi] = grant.valid;
        assign bus.grant_idx[gi]   = grant.idx;
        assign bus.grant_class[gi] = 2'(grant.fu_class);
        assign bus.grant_unit[gi]  = grant.unit;
    end

    assign mult_load = mult_free0 & ~slot_g[N_WAYS-1].mult_out;
    assign lsu_take  = lsu_free0 && !slot_g[N_WAYS-1].lsu_out;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mult_cnt_reg <= '0;
            lsu_busy_reg <= 1'b0;
        end else if (bus.squash) begin
            mult_cnt_reg <= '0;
            lsu_busy_reg <= 1'b0;
        end else begin
            for (int m = 0; m < N_MULT; m++) begin
                if (mult_load[m]) begin
                    mult_cnt_reg[m] <= MCNT_W'(MULT_BUSY - 1);
                end else if (mult_cnt_reg[m] != '0) begin
                    mult_cnt_reg[m] <= mult_cnt_reg[m] - MCNT_W'(1);
                end
            end
            if (lsu_take) begin
                lsu_busy_reg <= 1'b1;
            end else if (bus.lsu_done) begin
                lsu_busy_reg <= 1'b0;
            end
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0]      perf_issued_reg;
    logic [31:0]      perf_struct_stall_reg;
    logic [POP_W-1:0] issue_pop;
    logic [32:0]      issued_sum;
    logic [N_REQ-1:0] stall_vec;
    logic             struct_stall;

    always_comb begin
        issue_pop = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            issue_pop = issue_pop + POP_W'(bus.grant_valid[w]);
        end
    end

    // A stall only counts when a slot went unused, so the refusal was purely a unit shortage.
    always_comb begin
        stall_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            stall_vec[i] = bus.req_valid[i] && !slot_g[N_WAYS-1].taken_out[i] &&
                           (bus.req_class[i] != 2'(FU_RSVD)) &&
                           !class_has_unit(fu_class_t'(bus.req_class[i]),
                                           slot_g[N_WAYS-1].alu_out,
                                           slot_g[N_WAYS-1].mult_out,
                                           slot_g[N_WAYS-1].lsu_out);
        end
    end

    assign struct_stall = issue_gate && !bus.grant_valid[N_WAYS-1] && (|stall_vec);
    assign issued_sum   = {1'b0, perf_issued_reg} + 33'(issue_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_issued_reg       <= '0;
            perf_struct_stall_reg <= '0;
        end else begin
            perf_issued_reg <= issued_sum[32] ? '1 : issued_sum[31:0];
            if (struct_stall && (perf_struct_stall_reg != '1)) begin
                perf_struct_stall_reg <= perf_struct_stall_reg + 32'd1;
            end
        end
    end

    assign perf_issued       = perf_issued_reg;
    assign perf_struct_stall = perf_struct_stall_reg;
`endif

endmodule
